// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and default widths for the two-port Data_RAM arbiter.
package data_ram_arbiter_pkg;

    localparam int unsigned DefAddrW    = 10;
    localparam int unsigned DefDataW    = 32;
    localparam int unsigned DefBurstMax = 4;
    localparam int unsigned BurstCntW   = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StOwn0 = 2'd1,
        StOwn1 = 2'd2
    } state_e;

endpackage

// File: rtl/data_ram_arbiter_arb_rr2.sv
// Two-input round-robin pick: pick=1 selects port 1; on contention the port not served last wins.
module data_ram_arbiter_arb_rr2 (
    input  logic req0,
    input  logic req1,
    input  logic rr_last,
    output logic pick
);

    always_comb begin
        pick = 1'b0;
        if (req0 && req1) begin
            pick = ~rr_last;
        end else if (req1) begin
            pick = 1'b1;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbitrates a single-port Data_RAM between two masters with bounded bursts and
// round-robin hand-over; read results return one cycle after the grant.
module data_ram_arbiter
    import data_ram_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W    = DefAddrW,
    parameter int unsigned DATA_W    = DefDataW,
    parameter int unsigned BURST_MAX = DefBurstMax
) (
    input  logic              clk,
    input  logic              RSTN,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_wea,
    output logic [ADDR_W-1:0] ram_addra,
    output logic [DATA_W-1:0] ram_dina,
    input  logic [DATA_W-1:0] ram_douta
);

    localparam logic [BurstCntW-1:0] BurstLast = BurstCntW'(BURST_MAX - 1);

    state_e                 state_q, state_d;
    logic [BurstCntW-1:0]   burst_cnt_q, burst_cnt_d;
    logic                   rr_last_q, rr_last_d;
    logic                   rd_tag0_q, rd_tag1_q;
    logic                   pick;

    data_ram_arbiter_arb_rr2 u_arb_rr2 (
        .req0    (req0),
        .req1    (req1),
        .rr_last (rr_last_q),
        .pick    (pick)
    );

    // State register; read tags are registered from the grant, not from the state.
    always_ff @(posedge clk) begin
        if (!RSTN) begin
            state_q     <= StIdle;
            burst_cnt_q <= '0;
            rr_last_q   <= 1'b1;
            rd_tag0_q   <= 1'b0;
            rd_tag1_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rr_last_q   <= rr_last_d;
            rd_tag0_q   <= gnt0 & ~we0;
            rd_tag1_q   <= gnt1 & ~we1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (req0 || req1) state_d = pick ? StOwn1 : StOwn0;
            end
            StOwn0: begin
                if (!req0) begin
                    state_d = req1 ? StOwn1 : StIdle;
                end else if (req1 && burst_cnt_q == BurstLast) begin
                    state_d = StOwn1;
                end
            end
            StOwn1: begin
                if (!req1) begin
                    state_d = req0 ? StOwn0 : StIdle;
                end else if (req0 && burst_cnt_q == BurstLast) begin
                    state_d = StOwn0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Burst count saturates at the yield point so a late-arriving requester waits at most one transfer.
    always_comb begin
        burst_cnt_d = burst_cnt_q;
        rr_last_d   = rr_last_q;
        if (state_d != state_q) begin
            burst_cnt_d = '0;
            if (state_q == StOwn0) begin
                rr_last_d = 1'b0;
            end else if (state_q == StOwn1) begin
                rr_last_d = 1'b1;
            end
        end else if ((gnt0 || gnt1) && burst_cnt_q != BurstLast) begin
            burst_cnt_d = burst_cnt_q + BurstCntW'(1);
        end
    end

    always_comb begin
        gnt0      = RSTN && (state_q == StOwn0) && req0;
        gnt1      = RSTN && (state_q == StOwn1) && req1;
        ram_wea   = 1'b0;
        ram_addra = '0;
        ram_dina  = '0;
        unique case (state_q)
            StOwn0: begin
                ram_addra = addr0;
                ram_dina  = wdata0;
                ram_wea   = gnt0 & we0;
            end
            StOwn1: begin
                ram_addra = addr1;
                ram_dina  = wdata1;
                ram_wea   = gnt1 & we1;
            end
            default: ;
        endcase
    end

    assign rvalid0 = rd_tag0_q;
    assign rvalid1 = rd_tag1_q;
    assign rdata   = ram_douta;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Randomised and directed bench for data_ram_arbiter against an ownership/queue-level reference model.
module tb_data_ram_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int BM = 4;
    localparam int VW = 5 + AW + 2 * DW;

    logic          clk = 1'b0;
    logic          RSTN;
    logic          req0, req1, we0, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1, ram_wea;
    logic [DW-1:0] rdata, ram_dina, ram_douta;
    logic [AW-1:0] ram_addra;

    int   checks = 0;
    int   passes = 0;
    logic ram_init = 1'b1;
    logic mon_en = 1'b0;

    always #5 clk = ~clk;

    data_ram_arbiter #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .BURST_MAX (BM)
    ) dut (
        .clk       (clk),
        .RSTN      (RSTN),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_douta (ram_douta)
    );

    function automatic logic [DW-1:0] init_word(int i);
        return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Single-port RAM with one-cycle read latency.
    logic [DW-1:0] mem [1 << AW];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= init_word(i);
        end else if (ram_wea) begin
            mem[ram_addra] <= ram_dina;
        end
        ram_douta <= mem[ram_addra];
    end

    // Reference model: owner (-1 none), transfers so far in this tenure, last served port.
    int            m_own = -1, m_run = 0, m_last = 1;
    int            m_own_nx, m_run_nx, m_last_nx;
    logic          req_me, req_ot;
    logic          e_rv0 = 1'b0, e_rv1 = 1'b0;
    logic [DW-1:0] e_rdata = '0;
    logic [DW-1:0] shadow [1 << AW];
    logic          e_gnt0, e_gnt1, e_wea;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_din;

    always_comb begin
        e_gnt0 = RSTN && m_own == 0 && req0;
        e_gnt1 = RSTN && m_own == 1 && req1;
        e_addr = (m_own == 0) ? addr0 : (m_own == 1) ? addr1 : '0;
        e_din  = (m_own == 0) ? wdata0 : (m_own == 1) ? wdata1 : '0;
        e_wea  = (e_gnt0 && we0) || (e_gnt1 && we1);
    end

    always_comb begin
        m_own_nx  = m_own;
        m_run_nx  = m_run;
        m_last_nx = m_last;
        req_me    = (m_own == 0) ? req0 : req1;
        req_ot    = (m_own == 0) ? req1 : req0;
        if (m_own < 0) begin
            if (req0 && req1) m_own_nx = (m_last == 1) ? 0 : 1;
            else if (req0) m_own_nx = 0;
            else if (req1) m_own_nx = 1;
            m_run_nx = 0;
        end else begin
            if (!req_me) m_own_nx = req_ot ? 1 - m_own : -1;
            else if (req_ot && m_run >= BM - 1) m_own_nx = 1 - m_own;
            else m_run_nx = m_run + 1;
            if (m_own_nx != m_own) begin
                m_last_nx = m_own;
                m_run_nx  = 0;
            end
        end
    end

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < (1 << AW); i++) shadow[i] <= init_word(i);
        end
        if (!RSTN) begin
            m_own  <= -1;
            m_run  <= 0;
            m_last <= 1;
            e_rv0  <= 1'b0;
            e_rv1  <= 1'b0;
        end else begin
            if (e_wea) shadow[e_addr] <= e_din;
            if (e_gnt0 || e_gnt1) e_rdata <= shadow[e_addr];
            e_rv0  <= e_gnt0 && !we0;
            e_rv1  <= e_gnt1 && !we1;
            m_own  <= m_own_nx;
            m_run  <= m_run_nx;
            m_last <= m_last_nx;
        end
    end

    logic [VW-1:0] obs_v, exp_v;
    assign obs_v = {gnt0, gnt1, ram_wea, rvalid0, rvalid1, ram_addra, ram_dina,
                    (e_rv0 || e_rv1) ? rdata : {DW{1'b0}}};
    assign exp_v = {e_gnt0, e_gnt1, e_wea, e_rv0, e_rv1, e_addr, e_din,
                    (e_rv0 || e_rv1) ? e_rdata : {DW{1'b0}}};

    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (gnt0 && gnt1) $display("FAIL dual_grant t=%0t gnt0=1 gnt1=1 want not both", $time);
            else passes++;
            checks++;
            if (ram_wea && !(gnt0 ^ gnt1))
                $display("FAIL wea_grant t=%0t wea=1 gnt0=%b gnt1=%b want exactly one", $time, gnt0,
                         gnt1);
            else passes++;
        end
    end

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        RSTN = 0;
        idle_inputs();
        req0 = 1; req1 = 1; we0 = 1; we1 = 1;
        next_cycle();
        ram_init = 0;
        next_cycle();
        mon_en = 1;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, ram_wea, rvalid0, rvalid1} !== 5'b0)
            $display("FAIL reset_outputs got %b want 00000", {gnt0, gnt1, ram_wea, rvalid0, rvalid1});
        else passes++;
        next_cycle();
        RSTN = 1;
        idle_inputs();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL reset_idle got %h want %h", obs_v, exp_v);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_single_read();
        req0 = 1; we0 = 0; addr0 = 10'h005;
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b0) $display("FAIL read_arb_cycle gnt0=%b want 0", gnt0);
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({gnt0, ram_addra} !== {1'b1, 10'h005})
            $display("FAIL read_grant gnt0=%b addr=%h want 1 005", gnt0, ram_addra);
        else passes++;
        next_cycle();
        req0 = 0;
        @(negedge clk);
        checks++;
        if ({rvalid0, rvalid1, rdata} !== {2'b10, init_word(5)})
            $display("FAIL read_data rv0=%b rv1=%b rdata=%h want 1 0 %h", rvalid0, rvalid1, rdata,
                     init_word(5));
        else passes++;
        next_cycle();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL read_settle got %h want %h", obs_v, exp_v);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_contention();
        logic [1:0] want;
        RSTN = 0;
        idle_inputs();
        next_cycle();
        RSTN = 1;
        req0 = 1; req1 = 1;
        for (int c = 0; c < 13; c++) begin
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            want = (c == 0) ? 2'b00 : ((((c - 1) / 4) % 2) == 0) ? 2'b10 : 2'b01;
            @(negedge clk);
            checks++;
            if ({gnt0, gnt1} !== want)
                $display("FAIL burst_pattern c=%0d got %b want %b", c, {gnt0, gnt1}, want);
            else passes++;
            checks++;
            if (obs_v !== exp_v) $display("FAIL burst_model c=%0d got %h want %h", c, obs_v, exp_v);
            else passes++;
            next_cycle();
        end
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL burst_settle got %h want %h", obs_v, exp_v);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_write_read();
        logic seen_rv1 = 0;
        logic got = 0;
        req1 = 1; we1 = 1; addr1 = 10'h3FF; wdata1 = 32'hDEAD_BEEF;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL wr_model got %h want %h", obs_v, exp_v);
            else passes++;
            seen_rv1 |= rvalid1;
            got = gnt1;
            next_cycle();
        end
        checks++;
        if (!got) $display("FAIL wr_grant_timeout gnt1=0 want 1 within 10 cycles");
        else passes++;
        idle_inputs();
        req0 = 1; we0 = 0; addr0 = 10'h3FF;
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL rd_model got %h want %h", obs_v, exp_v);
            else passes++;
            seen_rv1 |= rvalid1;
            got = gnt0;
            next_cycle();
        end
        checks++;
        if (!got) $display("FAIL rd_grant_timeout gnt0=0 want 1 within 10 cycles");
        else passes++;
        idle_inputs();
        @(negedge clk);
        seen_rv1 |= rvalid1;
        checks++;
        if ({rvalid0, rdata} !== {1'b1, 32'hDEAD_BEEF})
            $display("FAIL wr_rd_data rv0=%b rdata=%h want 1 deadbeef", rvalid0, rdata);
        else passes++;
        next_cycle();
        checks++;
        if (seen_rv1 !== 1'b0) $display("FAIL wr_no_rvalid1 seen=%b want 0", seen_rv1);
        else passes++;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL wr_settle got %h want %h", obs_v, exp_v);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_yield_read();
        int n0 = 0;
        logic hit = 0;
        RSTN = 0;
        idle_inputs();
        next_cycle();
        RSTN = 1;
        req0 = 1; we0 = 0; req1 = 1; we1 = 1;
        for (int c = 0; c < 20 && !hit; c++) begin
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            wdata1 = $urandom;
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL yield_model got %h want %h", obs_v, exp_v);
            else passes++;
            if (gnt0) n0++;
            hit = gnt0 && n0 == BM;
            next_cycle();
        end
        @(negedge clk);
        checks++;
        if (!hit || {rvalid0, rvalid1, gnt1} !== 3'b101)
            $display("FAIL yield_rvalid hit=%b rv0=%b rv1=%b gnt1=%b want 1 1 0 1", hit, rvalid0,
                     rvalid1, gnt1);
        else passes++;
        checks++;
        if (obs_v !== exp_v) $display("FAIL yield_data got %h want %h", obs_v, exp_v);
        else passes++;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL yield_settle got %h want %h", obs_v, exp_v);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_reset_mid_burst();
        int n1 = 0;
        req1 = 1; we1 = 1;
        for (int c = 0; c < 10 && n1 < 2; c++) begin
            addr1 = AW'($urandom);
            wdata1 = $urandom;
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL rstb_model got %h want %h", obs_v, exp_v);
            else passes++;
            if (gnt1) n1++;
            next_cycle();
        end
        RSTN = 0;
        @(negedge clk);
        checks++;
        if (n1 != 2 || {ram_wea, gnt1} !== 2'b00)
            $display("FAIL rstb_wea n1=%0d wea=%b gnt1=%b want 2 0 0", n1, ram_wea, gnt1);
        else passes++;
        next_cycle();
        RSTN = 1;
        req0 = 1; req1 = 1; we0 = 0; we1 = 0;
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1, rvalid0, rvalid1} !== 4'b0000)
            $display("FAIL rstb_idle got %b want 0000", {gnt0, gnt1, rvalid0, rvalid1});
        else passes++;
        next_cycle();
        @(negedge clk);
        checks++;
        if ({gnt0, gnt1} !== 2'b10) $display("FAIL rstb_first_win got %b want 10", {gnt0, gnt1});
        else passes++;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL rstb_settle got %h want %h", obs_v, exp_v);
            else passes++;
            next_cycle();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            RSTN   = ($urandom_range(0, 49) != 0);
            req0   = ($urandom_range(0, 2) != 0);
            req1   = ($urandom_range(0, 2) != 0);
            we0    = $urandom_range(0, 1) != 0;
            we1    = $urandom_range(0, 1) != 0;
            addr0  = AW'($urandom_range(0, 15));
            addr1  = AW'($urandom_range(0, 15));
            wdata0 = $urandom;
            wdata1 = $urandom;
            @(negedge clk);
            checks++;
            if (obs_v !== exp_v) $display("FAIL random c=%0d got %h want %h", c, obs_v, exp_v);
            else passes++;
            next_cycle();
        end
        RSTN = 1;
        idle_inputs();
    endtask

    initial begin
        RSTN = 0;
        idle_inputs();
        test_reset();
        test_single_read();
        test_contention();
        test_write_read();
        test_yield_read();
        test_reset_mid_burst();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, meaning the Data_RAM word-address width.
REQ-002 The block SHALL have parameter DATA_W, default 32, meaning the data width.
REQ-003 The block SHALL have parameter BURST_MAX, default 4, meaning the maximum consecutive transfers one owner keeps while the other port waits (legal range 1..15).
REQ-004 The block SHALL have port clk, input, 1, the single system clock (clk_100mhz domain); all logic is rising-edge.
REQ-005 The block SHALL have port RSTN, input, 1, the reset: synchronous and active-low.
REQ-006 The block SHALL have ports req0/req1, input, 1, the access request of port 0 (CPU via MIO) and port 1 (secondary master, e.g. DMA or debug).
REQ-007 The block SHALL have ports we0/we1, input, 1, write enable qualifying the request (1=write, 0=read).
REQ-008 The block SHALL have ports addr0/addr1, input, ADDR_W, the word address.
REQ-009 The block SHALL have ports wdata0/wdata1, input, DATA_W, the write data.
REQ-010 The block SHALL have ports gnt0/gnt1, output, 1, asserted when the request is accepted this cycle.
REQ-011 The block SHALL have ports rvalid0/rvalid1, output, 1, asserted when rdata holds that port's read result.
REQ-012 The block SHALL have port rdata, output, DATA_W, the shared read data (equal to ram_douta).
REQ-013 The block SHALL have ports ram_wea (output, 1), ram_addra (output, ADDR_W), ram_dina (output, DATA_W) and ram_douta (input, DATA_W), the single-port RAM interface with 1-cycle read latency.

Function
REQ-014 The FSM SHALL have the states IDLE, OWN0 and OWN1, encoded in the shared package; the reset state SHALL be IDLE.
REQ-015 A transfer SHALL occur on port n in a cycle when state==OWNn and reqn=1; gntn SHALL be combinational and equal to (state==OWNn & reqn).
REQ-016 The RAM inputs SHALL be multiplexed from the owning port: ram_addra=addr_n, ram_dina=wdata_n, ram_wea=gntn & wen; in IDLE, ram_wea=0 and addr/din SHALL be 0.
REQ-017 The read latency SHALL be one cycle: after a read transfer on port n, rvalidn=1 for exactly one cycle in the next cycle, with rdata=ram_douta.
REQ-018 A write transfer SHALL NOT assert rvalid.
REQ-019 From IDLE, the next state SHALL be OWN0 for req0 only and OWN1 for req1 only; when both request, the next state SHALL be the port not served last (rr_last flag, reset value 1, so port 0 wins first).
REQ-020 In IDLE no grant SHALL be given, so arbitration costs one cycle.
REQ-021 In OWNn with reqn=0, the next state SHALL be OWN(other) if the other port requests, otherwise IDLE.
REQ-022 In OWNn with reqn=1 and the other port idle, the state SHALL remain OWNn indefinitely; burst_cnt SHALL saturate.
REQ-023 In OWNn with both ports requesting and burst_cnt==BURST_MAX-1 on a transfer, the next state SHALL be OWN(other) (forced yield).
REQ-024 burst_cnt SHALL increment per transfer and clear on every ownership change; rr_last SHALL update to n on every OWNn exit.
REQ-025 When a read completes while ownership changes, the rvalid of the issuing port SHALL still fire; the read tag SHALL be registered, not derived from the current state.
REQ-026 The outputs SHALL never assert both grants; a requester dropping req without a grant SHALL be legal, and addr/we SHALL be sampled only at the grant.

Reset
REQ-027 While RSTN=0 at a clock edge, the block SHALL set state=IDLE, burst_cnt=0, rr_last=1 and clear the read tags and rvalid0/1.
REQ-028 During reset, gnt0/gnt1 and ram_wea SHALL be forced 0 combinationally.
REQ-029 A reset mid-burst SHALL drop any pending rvalid without a spurious RAM write.

Structure
REQ-030 A shared package SHALL hold the state enum (IDLE/OWN0/OWN1) and the default widths.
REQ-031 One sub-module, arb_rr2 (two-input round-robin pick with rr_last), is natural; the remainder SHALL be flat.

Verification
REQ-032 The bench SHALL cover: reset release, req0 read addr 0x005 -> IDLE->OWN0, gnt0 one cycle later, rvalid0 the following cycle with rdata=RAM[5].
REQ-033 The bench SHALL cover: req0 and req1 raised together from reset -> port 0 granted first; with both held, grants follow the pattern 4x gnt0, 4x gnt1, 4x gnt0 (BURST_MAX=4).
REQ-034 The bench SHALL cover: port 1 write 0xDEADBEEF to 0x3FF, then port 0 read 0x3FF -> rdata=0xDEADBEEF, rvalid1 never asserted.
REQ-035 The bench SHALL cover: port 0 read on the last burst cycle, then ownership moves to port 1 -> rvalid0 (not rvalid1) fires the next cycle.
REQ-036 The bench SHALL cover: RSTN low during an OWN1 write burst -> ram_wea=0 in the same cycle, state IDLE, rvalid 0, and port 0 then wins the first contention.
REQ-037 The bench SHALL check continuously that gnt0&gnt1 is never 1 and that ram_wea implies exactly one gnt.
